// File: rtl/debug_pkg.sv
// debug_pkg: shared opcodes, FSM states, halt cause codes and STATUS word layout for the debug controller
package debug_pkg;

    typedef enum logic [2:0] {
        OP_HALT    = 3'd0,
        OP_RESUME  = 3'd1,
        OP_STEP    = 3'd2,
        OP_READREG = 3'd3,
        OP_SETBP   = 3'd4,
        OP_CLRBP   = 3'd5,
        OP_STATUS  = 3'd6
    } dbg_op_e;

    typedef enum logic [1:0] {
        S_RUN,
        S_HALTED,
        S_STEP,
        S_RDREG
    } dbg_state_e;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_HOST = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd2;
    localparam logic [1:0] CAUSE_STEP = 2'd3;

    // STATUS word: halted at bit 0, cause at [2:1], bit 3 reserved, hit index nibble-aligned at [7:4]
    localparam int ST_HALTED_OFS = 0;
    localparam int ST_CAUSE_OFS  = 1;
    localparam int ST_IDX_OFS    = 4;

endpackage

// File: rtl/bp_match.sv
// bp_match: PC breakpoint register file with set/clear and lowest-index hit encoder
// Ports:
//   clk, Rst            clock, synchronous active-high reset (clears all breakpoints)
//   set_i, clr_i        write enable / disable of breakpoint idx_i (ignored when idx_i >= NBP)
//   idx_i, data_i       breakpoint index and PC to store on set
//   pc_i                PC compared against every enabled breakpoint
//   hit_o, hit_idx_o    any enabled match, lowest matching index
module bp_match #(
    parameter int XLEN = 32,
    parameter int NBP  = 4,
    parameter int IW   = 5
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            set_i,
    input  logic            clr_i,
    input  logic [IW-1:0]   idx_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            hit_o,
    output logic [3:0]      hit_idx_o
);

    logic [XLEN-1:0] pc_q [NBP];
    logic [NBP-1:0]  en_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBP; i++) begin
            if (Rst) begin
                pc_q[i] <= '0;
                en_q[i] <= 1'b0;
            end else if (int'(idx_i) == i) begin
                if (set_i) begin
                    pc_q[i] <= data_i;
                    en_q[i] <= 1'b1;
                end else if (clr_i) begin
                    en_q[i] <= 1'b0;
                end
            end
        end
    end

    // Scan from the top down so the lowest matching index is the one left standing
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = NBP - 1; i >= 0; i--) begin
            if (en_q[i] && pc_q[i] == pc_i) begin
                hit_o     = 1'b1;
                hit_idx_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/core_debug_ctrl.sv
// core_debug_ctrl: host debug controller (halt/resume/step/register read/PC breakpoints) for the core pipeline
// Ports:
//   cmd_valid/cmd_ready/cmd_op/cmd_idx/cmd_data   host command channel
//   rsp_valid/rsp_ready/rsp_data/rsp_err          host response channel, held until consumed
//   core_pc, core_retire                          IF/ID PC and pipeline-advance indication
//   core_halt                                     pipeline stall (dbg)
//   reg_addr, reg_rdata                           register-file debug read port
//   halted, bp_evt                                HALTED state flag, one-cycle breakpoint-halt pulse
module core_debug_ctrl
    import debug_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NBP    = 4,
    parameter  int REG_AW = 5,
    localparam int IW     = (REG_AW > $clog2(NBP)) ? REG_AW : $clog2(NBP)
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [IW-1:0]     cmd_idx,
    input  logic [XLEN-1:0]   cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_err,
    input  logic [XLEN-1:0]   core_pc,
    input  logic              core_retire,
    output logic              core_halt,
    output logic [REG_AW-1:0] reg_addr,
    input  logic [XLEN-1:0]   reg_rdata,
    output logic              halted,
    output logic              bp_evt
);

    dbg_state_e        state_q, state_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]        cause_q, cause_d;
    logic [3:0]        hit_idx_q, hit_idx_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic              bp_evt_q, bp_evt_d, core_halt_q, halted_q;
    logic              pend_q, pend_d;
    logic              accept, idx_ok, bp_set, bp_clr, hit;
    logic [3:0]        hit_idx;

    // pend_q marks the cycle after a step retires: the new PC is only visible then, so the step response is built there
    assign cmd_ready = !rsp_valid_q && !pend_q && (state_q == S_RUN || state_q == S_HALTED);
    assign accept    = cmd_valid && cmd_ready;
    assign idx_ok    = int'(cmd_idx) < NBP;

    bp_match #(.XLEN(XLEN), .NBP(NBP), .IW(IW)) u_bp (
        .clk       (clk),
        .Rst       (Rst),
        .set_i     (bp_set),
        .clr_i     (bp_clr),
        .idx_i     (cmd_idx),
        .data_i    (cmd_data),
        .pc_i      (core_pc),
        .hit_o     (hit),
        .hit_idx_o (hit_idx)
    );

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cause_d     = cause_q;
        hit_idx_d   = hit_idx_q;
        reg_addr_d  = reg_addr_q;
        bp_evt_d    = 1'b0;
        pend_d      = 1'b0;
        bp_set      = 1'b0;
        bp_clr      = 1'b0;
        if (state_q == S_RUN && hit) begin
            state_d   = S_HALTED;
            cause_d   = CAUSE_BP;
            hit_idx_d = hit_idx;
            bp_evt_d  = 1'b1;
        end
        if (state_q == S_STEP && core_retire) begin
            state_d = S_HALTED;
            cause_d = CAUSE_STEP;
            pend_d  = 1'b1;
        end
        if (state_q == S_RDREG) begin
            state_d     = S_HALTED;
            rsp_valid_d = 1'b1;
            rsp_data_d  = reg_rdata;
            rsp_err_d   = 1'b0;
        end
        if (pend_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = core_pc;
            rsp_err_d   = 1'b0;
        end
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b0;
            case (cmd_op)
                OP_HALT: begin
                    rsp_data_d = core_pc;
                    // A simultaneous breakpoint hit already halts and owns the cause
                    if (state_q == S_RUN && !hit) begin
                        state_d = S_HALTED;
                        cause_d = CAUSE_HOST;
                    end
                end
                OP_RESUME: begin
                    if (state_q == S_HALTED) state_d = S_RUN;
                    else rsp_err_d = 1'b1;
                end
                OP_STEP: begin
                    if (state_q == S_HALTED) begin
                        state_d     = S_STEP;
                        rsp_valid_d = 1'b0;
                    end else rsp_err_d = 1'b1;
                end
                OP_READREG: begin
                    if (state_q == S_HALTED) begin
                        state_d     = S_RDREG;
                        reg_addr_d  = cmd_idx[REG_AW-1:0];
                        rsp_valid_d = 1'b0;
                    end else rsp_err_d = 1'b1;
                end
                OP_SETBP: begin
                    bp_set    = idx_ok;
                    rsp_err_d = !idx_ok;
                end
                OP_CLRBP: begin
                    bp_clr    = idx_ok;
                    rsp_err_d = !idx_ok;
                end
                OP_STATUS: begin
                    rsp_data_d[ST_HALTED_OFS]     = halted_q;
                    rsp_data_d[ST_CAUSE_OFS +: 2] = cause_q;
                    rsp_data_d[ST_IDX_OFS +: 4]   = hit_idx_q;
                end
                default: rsp_err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q     <= S_RUN;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cause_q     <= CAUSE_NONE;
            hit_idx_q   <= '0;
            reg_addr_q  <= '0;
            bp_evt_q    <= 1'b0;
            pend_q      <= 1'b0;
            core_halt_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cause_q     <= cause_d;
            hit_idx_q   <= hit_idx_d;
            reg_addr_q  <= reg_addr_d;
            bp_evt_q    <= bp_evt_d;
            pend_q      <= pend_d;
            core_halt_q <= state_d == S_HALTED || state_d == S_RDREG;
            halted_q    <= state_d == S_HALTED;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign reg_addr  = reg_addr_q;
    assign bp_evt    = bp_evt_q;
    assign core_halt = core_halt_q;
    assign halted    = halted_q;

endmodule
